// File: rtl/apx_add_err_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor: default widths,
// pipeline depth and FSM state encoding.
package apx_add_err_monitor_pkg;

  localparam int unsigned OP_BITWIDTH_DEF = 16;
  localparam int unsigned DP_W_DEF        = 32;
  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned ACC_W_DEF       = 48;
  localparam int unsigned PIPE_DEPTH      = 2;
  localparam int unsigned DRAIN_W         = $clog2(PIPE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/apx_err_calc.sv
// Error datapath: exact OP-bit signed sum, difference against the approximate
// result (registered as stage S1) and its absolute value.
module apx_err_calc
  import apx_add_err_monitor_pkg::*;
#(
  parameter int unsigned OP_W = OP_BITWIDTH_DEF,
  parameter int unsigned DP_W = DP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_fire,
  input  logic [DP_W-1:0] a,
  input  logic [DP_W-1:0] b,
  input  logic [DP_W-1:0] c,
  output logic            s1_valid,
  output logic [DP_W:0]   s1_diff,
  output logic [DP_W:0]   absd_c
);

  logic [OP_W:0] exact_c;
  logic [DP_W:0] exact_ext_c;
  logic [DP_W:0] c_ext_c;
  logic [DP_W:0] diff_c;
  logic          unused_hi_c;

  // Operand bits above OP_W are not part of the active width.
  assign unused_hi_c = ^{a[DP_W-1:OP_W], b[DP_W-1:OP_W]};

  // Two's-complement arithmetic on explicitly sign-extended vectors.
  assign exact_c     = {a[OP_W-1], a[OP_W-1:0]} + {b[OP_W-1], b[OP_W-1:0]};
  assign exact_ext_c = {{(DP_W - OP_W){exact_c[OP_W]}}, exact_c};
  assign c_ext_c     = {c[DP_W-1], c};
  assign diff_c      = c_ext_c - exact_ext_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else begin
      s1_valid <= in_fire;
      s1_diff  <= diff_c;
    end
  end

  // The most-negative diff cannot occur, so negation never overflows.
  assign absd_c = s1_diff[DP_W] ? ((~s1_diff) + (DP_W + 1)'(1)) : s1_diff;

endmodule

// File: rtl/apx_add_err_monitor.sv
// Approximate-adder error monitor: windowed FSM, sample counting and
// mismatch / |error| sum / |error| max statistics.
module apx_add_err_monitor
  import apx_add_err_monitor_pkg::*;
#(
  parameter int unsigned OP_BITWIDTH        = OP_BITWIDTH_DEF,
  parameter int unsigned DATA_PATH_BITWIDTH = DP_W_DEF,
  parameter int unsigned CNT_W              = CNT_W_DEF,
  parameter int unsigned ACC_W              = ACC_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [CNT_W-1:0]              num_samples,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  input  logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              sample_cnt,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [ACC_W-1:0]              err_sum,
  output logic [DATA_PATH_BITWIDTH:0]   err_max
);

  localparam int unsigned DP_W = DATA_PATH_BITWIDTH;

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    target_q;
  logic [CNT_W-1:0]    acc_cnt_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic                fire_c;
  logic                arm_c;
  logic                last_c;
  logic                s1_valid;
  logic [DP_W:0]       s1_diff;
  logic [DP_W:0]       absd_c;
  logic [ACC_W:0]      sum_ext_c;

  apx_err_calc #(
    .OP_W (OP_BITWIDTH),
    .DP_W (DP_W)
  ) u_calc (
    .clk      (clk),
    .rst      (rst),
    .in_fire  (fire_c),
    .a        (a),
    .b        (b),
    .c        (c),
    .s1_valid (s1_valid),
    .s1_diff  (s1_diff),
    .absd_c   (absd_c)
  );

  assign fire_c = in_valid && in_ready;
  assign arm_c  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_c = fire_c && (acc_cnt_q == (target_q - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (num_samples == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_W'(PIPE_DEPTH - 1)) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Saturating add: the carry out of the widened sum selects the clamp.
  assign sum_ext_c = {1'b0, err_sum} + (ACC_W + 1)'(absd_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q   <= '0;
      acc_cnt_q  <= '0;
      drain_q    <= '0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
      err_max    <= '0;
    end else begin
      drain_q <= (state_q == ST_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
      if (arm_c) begin
        target_q   <= num_samples;
        acc_cnt_q  <= '0;
        sample_cnt <= '0;
        err_cnt    <= '0;
        err_sum    <= '0;
        err_max    <= '0;
      end else begin
        if (fire_c) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (s1_valid) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          if (absd_c != '0) err_cnt <= err_cnt + CNT_W'(1);
          err_sum <= sum_ext_c[ACC_W] ? '1 : sum_ext_c[ACC_W-1:0];
          if (absd_c > err_max) err_max <= absd_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_apx_add_err_monitor.sv
// Self-checking bench for apx_add_err_monitor: directed windows plus randomized
// windows checked against an arithmetic reference model of the error statistics.
module tb_apx_add_err_monitor;

  localparam int unsigned OP = 16;
  localparam int unsigned DP = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          in_valid;
  logic          in_ready;
  logic [DP-1:0] a, b, c;
  logic          busy, done;
  logic [CW-1:0] sample_cnt, err_cnt;
  logic [AW-1:0] err_sum;
  logic [DP:0]   err_max;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DP-1:0] qa[$], qb[$], qc[$];
  logic [DP-1:0] xa[$], xb[$], xc[$];

  apx_add_err_monitor #(
    .OP_BITWIDTH (OP), .DATA_PATH_BITWIDTH (DP), .CNT_W (CW), .ACC_W (AW)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .num_samples (num_samples),
    .in_valid (in_valid), .in_ready (in_ready), .a (a), .b (b), .c (c),
    .busy (busy), .done (done), .sample_cnt (sample_cnt), .err_cnt (err_cnt),
    .err_sum (err_sum), .err_max (err_max)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=hang required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact signed OP-bit sum versus signed DP-bit c, as plain integers.
  function automatic longint abs_err(input logic [DP-1:0] aa, input logic [DP-1:0] bb,
                                     input logic [DP-1:0] cc);
    logic [OP-1:0] la, lb;
    longint ex, cv, d;
    la = aa[OP-1:0];
    lb = bb[OP-1:0];
    ex = $signed(la);
    ex = ex + $signed(lb);
    cv = $signed(cc);
    d  = cv - ex;
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [DP-1:0] exact_plus(input logic [DP-1:0] aa, input logic [DP-1:0] bb,
                                               input int e);
    logic [OP-1:0] la, lb;
    longint ex;
    la = aa[OP-1:0];
    lb = bb[OP-1:0];
    ex = $signed(la);
    ex = ex + $signed(lb) + e;
    return DP'(ex);
  endfunction

  task automatic push(input logic [DP-1:0] pa, input logic [DP-1:0] pb, input logic [DP-1:0] pc);
    qa.push_back(pa); qb.push_back(pb); qc.push_back(pc);
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qc.delete();
    xa.delete(); xb.delete(); xc.delete();
  endtask

  task automatic check_stats(input string name, input longint s_cnt, input longint e_cnt,
                             input longint e_sum, input longint e_max);
    check({name, "_sample_cnt"}, 64'(sample_cnt), 64'(s_cnt));
    check({name, "_err_cnt"},    64'(err_cnt),    64'(e_cnt));
    check({name, "_err_sum"},    64'(err_sum),    64'(e_sum));
    check({name, "_err_max"},    64'(err_max),    64'(e_max));
  endtask

  // Arms a window of n samples, streams the queued triples (mode 0: hold valid,
  // 1: every other cycle, 2: random) and checks the result against the model.
  task automatic run_window(input string name, input int n, input int mode);
    int cyc, last, xfers, idx, k;
    bit v, finished;
    longint ad, m_cnt, m_sum, m_max;
    @(negedge clk);
    start = 1'b1; num_samples = CW'(n);
    @(negedge clk);
    start = 1'b0;
    check({name, "_arm_busy"}, 64'(busy), 64'(1));
    check_stats({name, "_arm"}, 0, 0, 0, 0);
    cyc = 0; last = -1; xfers = 0; idx = 0; finished = 1'b0;
    while (!finished && cyc < 300) begin
      if (last >= 0) begin
        k = cyc - last;
        if (k == 1) check({name, "_ready_off"}, 64'(in_ready), 64'(0));
        if (k == 2) check({name, "_done_early"}, 64'(done), 64'(0));
        if (k == 3) begin
          check({name, "_done"}, 64'(done), 64'(1));
          finished = 1'b1;
        end
      end
      if (!finished) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 0;
          default: v = ($urandom % 3) != 0;
        endcase
        in_valid = v;
        if (idx < qa.size()) begin
          a = qa[idx]; b = qb[idx]; c = qc[idx];
        end else begin
          a = $urandom; b = $urandom; c = $urandom;
        end
        if (v && in_ready) begin
          xa.push_back(a); xb.push_back(b); xc.push_back(c);
          xfers++; idx++;
          if (xfers == n) last = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_valid = 1'b0;
    check({name, "_finished"}, 64'(finished), 64'(1));
    check({name, "_xfers"}, 64'(xfers), 64'(n));
    m_cnt = 0; m_sum = 0; m_max = 0;
    for (int i = 0; i < xa.size(); i++) begin
      ad = abs_err(xa[i], xb[i], xc[i]);
      if (ad != 0) m_cnt++;
      m_sum += ad;
      if (ad > m_max) m_max = ad;
    end
    check_stats(name, longint'(xa.size()), m_cnt, m_sum, m_max);
  endtask

  initial begin
    int n, kind, e;
    logic [DP-1:0] ra, rb, rc;
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    check_stats("rst", 0, 0, 0, 0);
    rst = 1'b0;

    // Exact results only.
    clear_q();
    push(32'd3, 32'd4, 32'd7);
    push(-32'sd5, 32'd2, -32'sd3);
    push(32'd100, -32'sd100, 32'd0);
    push(32'd0, 32'd0, 32'd0);
    run_window("t1", 4, 0);
    check_stats("t1_dir", 4, 0, 0, 0);

    // Two erroneous samples.
    clear_q();
    push(32'd10, 32'd20, 32'd28);
    push(32'd1, 32'd1, 32'd6);
    push(-32'sd8, -32'sd8, -32'sd16);
    run_window("t2", 3, 0);
    check_stats("t2_dir", 3, 2, 6, 4);

    // Sum overflowing OP bits is exact in OP+1 bits.
    clear_q();
    push(32'h0000_7FFF, 32'h0000_0001, 32'd32768);
    push(32'h0000_7FFF, 32'h0000_0001, 32'hFFFF_8000);
    run_window("t3", 2, 1);
    check_stats("t3_dir", 2, 1, 65536, 65536);

    // Gapped valid, window of 5.
    clear_q();
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rb = $urandom;
      push(ra, rb, exact_plus(ra, rb, i - 2));
    end
    run_window("t4", 5, 1);
    check_stats("t4_dir", 5, 4, 6, 2);

    // Zero-length window goes straight to DONE.
    @(negedge clk);
    start = 1'b1; num_samples = '0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    check("t5_done", 64'(done), 64'(1));
    check("t5_busy", 64'(busy), 64'(0));
    check_stats("t5", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;

    // Reset mid-window discards partial results.
    @(negedge clk);
    start = 1'b1; num_samples = CW'(8);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd1; c = 32'd9;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    check_stats("t6_rst", 0, 0, 0, 0);
    rst = 1'b0;
    clear_q();
    push(32'd5, 32'd6, 32'd14);
    run_window("t6", 1, 0);
    check_stats("t6_dir", 1, 1, 3, 3);
    // Restart from DONE clears the old results (checked at arm).
    clear_q();
    push(32'd1, 32'd2, 32'd3);
    push(32'd4, 32'd5, 32'd9);
    push(32'd7, 32'd8, 32'd15);
    run_window("t6b", 3, 2);

    // Randomized windows.
    for (int r = 0; r < 10; r++) begin
      clear_q();
      n = 1 + int'($urandom % 12);
      for (int i = 0; i < n; i++) begin
        ra = $urandom; rb = $urandom;
        kind = int'($urandom % 3);
        e = int'($urandom_range(0, 8)) - 4;
        if (kind == 0)      rc = exact_plus(ra, rb, 0);
        else if (kind == 1) rc = exact_plus(ra, rb, e);
        else                rc = $urandom;
        push(ra, rb, rc);
      end
      run_window($sformatf("rnd%0d", r), n, r % 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
